// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end: default data width,
// the fetch entry carried through the prefetch buffer, and the NOP encoding
// that ID substitutes whenever no valid instruction is presented.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of fetch_entry_t with push, pop and a
// flush that wins over both. Pointers are log2(DEPTH) bits wide and wrap
// naturally because DEPTH is a power of two. No overflow protection: the
// producer's credit rule guarantees a push never meets a full buffer.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  // Next pointer/occupancy/storage; flush discards everything.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + {{(CW-1){1'b0}}, push_i} - {{(CW-1){1'b0}}, pop_i};
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; empty slots are never presented.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_decrypt_unit.sv
// Instruction-fetch front end: sequential PC, ROM request, XOR decryption with
// a per-block key, prefetch buffering and redirect flush.
// Optional feature macro: FETCH_DECRYPT_EN. When undefined the raw ROM word
// is delivered, key_addr_o is tied to 0 and key_data_i is ignored.
// XLEN must equal riscv_pkg::XLEN because buffer entries use fetch_entry_t.
//
// Handshake: an instruction transfers to ID on a rising clock edge where
// inst_valid_o && inst_ready_i are both high (and no redirect is present);
// while inst_valid_o is high and inst_ready_i low, inst_o and pc_o hold.
module fetch_decrypt_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter int              KEY_LSB  = 4,
  parameter int              KEY_AW   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              imem_req_o,
  output logic [XLEN-1:0]   imem_addr_o,
  input  logic [XLEN-1:0]   imem_data_i,
  output logic [KEY_AW-1:0] key_addr_o,
  input  logic [XLEN-1:0]   key_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [XLEN-1:0]   inst_o,
  output logic [XLEN-1:0]   pc_o
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occ_after;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            issue;
  logic            push;
  logic            pop;
  logic            flush;
  logic [XLEN-1:0] dec_word;

  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc_i[1:0];

`ifdef FETCH_DECRYPT_EN
  assign dec_word   = imem_data_i ^ key_data_i;
  assign key_addr_o = fpc_q[KEY_LSB +: KEY_AW];
`else
  logic unused_key;
  assign unused_key = ^key_data_i;
  assign dec_word   = imem_data_i;
  assign key_addr_o = '0;
`endif

  // Credit check, request issue, PC advance and kill of in-flight responses.
  always_comb begin
    occ_after     = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q}
                  - {{CW{1'b0}}, pop};
    issue         = rst_i && !redirect_i && (occ_after < DEPTH_C);
    push          = inflight_q && !redirect_i;
    flush         = redirect_i;
    fpc_d         = fpc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (issue) begin
      inflight_pc_d = fpc_q;
    end
    if (redirect_i) begin
      fpc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (issue) begin
      fpc_d = fpc_q + XLEN'(4);
    end
  end

  // Fetch PC and in-flight tracking registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fpc_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign pop        = inst_valid_o && inst_ready_i && !redirect_i;
  assign push_entry = '{pc: inflight_pc_q, inst: dec_word};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign imem_req_o   = issue;
  assign imem_addr_o  = fpc_q;
  assign inst_valid_o = (fifo_count != '0);
  assign inst_o       = inst_valid_o ? head.inst : '0;
  assign pc_o         = inst_valid_o ? head.pc   : '0;

endmodule

// File: tb/tb_fetch_decrypt_unit.sv
// Directed bench for fetch_decrypt_unit. A second instance with a wrapping
// RESET_PC and DEPTH=2 covers PC wrap and minimum-depth throughput.
// Cycle 0 is the first cycle with rst_n high; inputs are driven at the
// falling edge and outputs sampled 1 time unit later.
module tb_fetch_decrypt_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        imem_req,  w_imem_req;
  logic [31:0] imem_addr, w_imem_addr;
  logic [31:0] imem_data, w_imem_data;
  logic [3:0]  key_addr,  w_key_addr;
  logic [31:0] key_data,  w_key_data;
  logic        valid,     w_valid;
  logic [31:0] inst,      w_inst;
  logic [31:0] pc,        w_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] key_word(input logic [3:0] i);
    return 32'hDEAD_BEEF ^ (32'h0101_0101 * {28'h0, i});
  endfunction

  // ROM contents: word index encrypted with the key of its 16-byte block.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {2'b00, a[31:2]} ^ key_word(a[7:4]);
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] p);
`ifdef FETCH_DECRYPT_EN
    return {2'b00, p[31:2]};
`else
    return rom_word(p);
`endif
  endfunction

  function automatic logic [3:0] exp_key_addr(input logic [31:0] a);
`ifdef FETCH_DECRYPT_EN
    return a[7:4];
`else
    return 4'h0;
`endif
  endfunction

  fetch_decrypt_unit #(
    .XLEN(32), .DEPTH(4), .KEY_LSB(4), .KEY_AW(4), .RESET_PC(32'h0000_0000)
  ) u_dut (
    .clk_i(clk), .rst_i(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_data_i(imem_data),
    .key_addr_o(key_addr), .key_data_i(key_data), .inst_valid_o(valid),
    .inst_ready_i(ready), .inst_o(inst), .pc_o(pc)
  );

  fetch_decrypt_unit #(
    .XLEN(32), .DEPTH(2), .KEY_LSB(4), .KEY_AW(4), .RESET_PC(32'hFFFF_FFF8)
  ) u_dut_wrap (
    .clk_i(clk), .rst_i(rst_n), .redirect_i(1'b0), .redirect_pc_i(32'h0),
    .imem_req_o(w_imem_req), .imem_addr_o(w_imem_addr), .imem_data_i(w_imem_data),
    .key_addr_o(w_key_addr), .key_data_i(w_key_data), .inst_valid_o(w_valid),
    .inst_ready_i(ready), .inst_o(w_inst), .pc_o(w_pc)
  );

  // Synchronous ROMs: data valid the cycle after the address.
  always @(posedge clk) begin
    imem_data   <= rom_word(imem_addr);
    key_data    <= key_word(key_addr);
    w_imem_data <= rom_word(w_imem_addr);
    w_key_data  <= key_word(w_key_addr);
  end

  // Overflow monitor: a push must never land on a full buffer without a pop.
  always @(negedge clk) begin
    if (rst_n && u_dut.push && !u_dut.pop && u_dut.fifo_count == 3'd4) begin
      n_checks++; n_fail++;
      $display("FAIL fifo_overflow main: push into full buffer, count=%0d required<4", u_dut.fifo_count);
    end
    if (rst_n && u_dut_wrap.push && !u_dut_wrap.pop && u_dut_wrap.fifo_count == 2'd2) begin
      n_checks++; n_fail++;
      $display("FAIL fifo_overflow wrap: push into full buffer, count=%0d required<2", u_dut_wrap.fifo_count);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    @(negedge clk); @(negedge clk); #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_req: req=%b addr=%h required req=0 addr=00000000", imem_req, imem_addr);
    end
    n_checks++;
    if (key_addr !== exp_key_addr(32'h0)) begin
      n_fail++; $display("FAIL reset_key_addr: got %h required %h", key_addr, exp_key_addr(32'h0));
    end
    n_checks++;
    if (valid !== 1'b0 || inst !== 32'h0 || pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: valid=%b inst=%h pc=%h required 0/0/0", valid, inst, pc);
    end
    n_checks++;
    if (w_imem_req !== 1'b0 || w_imem_addr !== 32'hFFFF_FFF8 || w_key_addr !== exp_key_addr(32'hFFFF_FFF8)) begin
      n_fail++; $display("FAIL reset_wrap: req=%b addr=%h key=%h required 0/fffffff8/%h",
                         w_imem_req, w_imem_addr, w_key_addr, exp_key_addr(32'hFFFF_FFF8));
    end
  endtask

  task automatic test_stream();
    do_reset(); ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); rst_n = 1'b1; #1;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * c)) begin
        n_fail++; $display("FAIL stream_req c%0d: req=%b addr=%h required 1/%h", c, imem_req, imem_addr, 32'(4 * c));
      end
      n_checks++;
      if (valid !== (c >= 2)) begin
        n_fail++; $display("FAIL stream_valid c%0d: got %b required %b", c, valid, (c >= 2));
      end else if (c >= 2) begin
        n_checks++;
        if (pc !== 32'(4 * (c - 2)) || inst !== exp_inst(32'(4 * (c - 2)))) begin
          n_fail++; $display("FAIL stream_data c%0d: pc=%h inst=%h required %h/%h",
                             c, pc, inst, 32'(4 * (c - 2)), exp_inst(32'(4 * (c - 2))));
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset(); ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); rst_n = 1'b1; #1;
      n_checks++;
      if (imem_req !== (c < 4) || (c < 4 && imem_addr !== 32'(4 * c))) begin
        n_fail++; $display("FAIL stall_req c%0d: req=%b addr=%h required req=%b", c, imem_req, imem_addr, (c < 4));
      end
      if (c >= 2) begin
        n_checks++;
        if (valid !== 1'b1 || pc !== 32'h0 || inst !== exp_inst(32'h0)) begin
          n_fail++; $display("FAIL stall_head c%0d: valid=%b pc=%h inst=%h required 1/0/%h", c, valid, pc, inst, exp_inst(32'h0));
        end
      end
    end
    for (int c = 8; c < 16; c++) begin
      @(negedge clk); ready = 1'b1; #1;
      if (c == 8) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
          n_fail++; $display("FAIL stall_resume_req: req=%b addr=%h required 1/00000010", imem_req, imem_addr);
        end
      end
      n_checks++;
      if (valid !== 1'b1 || pc !== 32'(4 * (c - 8)) || inst !== exp_inst(32'(4 * (c - 8)))) begin
        n_fail++; $display("FAIL stall_resume c%0d: valid=%b pc=%h inst=%h required 1/%h/%h",
                           c, valid, pc, inst, 32'(4 * (c - 8)), exp_inst(32'(4 * (c - 8))));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(); ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); rst_n = 1'b1;
    end
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h103; #1;
    n_checks++;
    if (imem_req !== 1'b0 || valid !== 1'b1 || pc !== 32'h0) begin
      n_fail++; $display("FAIL redir_cycle: req=%b valid=%b pc=%h required 0/1/00000000", imem_req, valid, pc);
    end
    @(negedge clk); redirect = 1'b0; ready = 1'b1; #1;
    n_checks++;
    if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL redir_next: valid=%b req=%b addr=%h required 0/1/00000100", valid, imem_req, imem_addr);
    end
    @(negedge clk); #1;
    n_checks++;
    if (valid !== 1'b0 || imem_addr !== 32'h104) begin
      n_fail++; $display("FAIL redir_gap: valid=%b addr=%h required 0/00000104", valid, imem_addr);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if (valid !== 1'b1 || pc !== 32'h100 + 32'(4 * k) || inst !== exp_inst(32'h100 + 32'(4 * k))) begin
        n_fail++; $display("FAIL redir_deliver k%0d: valid=%b pc=%h inst=%h required 1/%h/%h",
                           k, valid, pc, inst, 32'h100 + 32'(4 * k), exp_inst(32'h100 + 32'(4 * k)));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(); ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); rst_n = 1'b1;
    end
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h100; #1;
    n_checks++;
    if (valid !== 1'b1 || pc !== 32'h8) begin
      n_fail++; $display("FAIL b2b_head: valid=%b pc=%h required 1/00000008", valid, pc);
    end
    @(negedge clk); redirect_pc = 32'h200; #1;
    n_checks++;
    if (valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second: valid=%b req=%b required 0/0", valid, imem_req);
    end
    @(negedge clk); redirect = 1'b0; #1;
    n_checks++;
    if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_fail++; $display("FAIL b2b_target_req: valid=%b req=%b addr=%h required 0/1/00000200", valid, imem_req, imem_addr);
    end
    @(negedge clk); #1;
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_gap: valid=%b required 0", valid);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if (valid !== 1'b1 || pc !== 32'h200 + 32'(4 * k) || inst !== exp_inst(32'h200 + 32'(4 * k))) begin
        n_fail++; $display("FAIL b2b_deliver k%0d: valid=%b pc=%h inst=%h required 1/%h/%h",
                           k, valid, pc, inst, 32'h200 + 32'(4 * k), exp_inst(32'h200 + 32'(4 * k)));
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    logic [31:0] p;
    do_reset(); ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); rst_n = 1'b1; #1;
      a = 32'hFFFF_FFF8 + 32'(4 * c);
      n_checks++;
      if (w_imem_req !== 1'b1 || w_imem_addr !== a || w_key_addr !== exp_key_addr(a)) begin
        n_fail++; $display("FAIL wrap_req c%0d: req=%b addr=%h key=%h required 1/%h/%h",
                           c, w_imem_req, w_imem_addr, w_key_addr, a, exp_key_addr(a));
      end
      if (c >= 2) begin
        p = 32'hFFFF_FFF8 + 32'(4 * (c - 2));
        n_checks++;
        if (w_valid !== 1'b1 || w_pc !== p || w_inst !== exp_inst(p)) begin
          n_fail++; $display("FAIL wrap_deliver c%0d: valid=%b pc=%h inst=%h required 1/%h/%h",
                             c, w_valid, w_pc, w_inst, p, exp_inst(p));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); rst_n = 1'b1;
    end
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0 || pc !== 32'h0 || inst !== 32'h0) begin
      n_fail++; $display("FAIL midreset_state: valid=%b req=%b addr=%h pc=%h inst=%h required all 0",
                         valid, imem_req, imem_addr, pc, inst);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); rst_n = 1'b1; #1;
      n_checks++;
      if (valid !== (c >= 2) || imem_addr !== 32'(4 * c) || (c >= 2 && pc !== 32'(4 * (c - 2)))) begin
        n_fail++; $display("FAIL midreset_restart c%0d: valid=%b addr=%h pc=%h required %b/%h/%h",
                           c, valid, imem_addr, pc, (c >= 2), 32'(4 * c), 32'(4 * (c - 2)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
